piso_buffer: RTL and testbench

//   Parallel-input single-output slot buffer: LENGTH producers each own one slot and

---
 rtl/reusable_pkg.sv | 9 +
 rtl/piso_buffer_rr_select.sv | 35 +++
 rtl/piso_buffer.sv | 79 +++++++
 tb/tb_piso_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reusable_pkg.sv
// Shared helpers for index-width computation across slot-based buffers.
package reusable_pkg;

    // Index width that never collapses to zero bits, even for tiny slot counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_buffer_rr_select.sv
// Round-robin selector: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then add ptr back to recover the absolute slot index.
module rr_select
    import reusable_pkg::*;
#(
    parameter int LENGTH = 8,
    localparam int IDX_W = clog2_min1(LENGTH)
) (
    input  logic [LENGTH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);

    logic [LENGTH-1:0] rot_req;
    logic [IDX_W-1:0]  rot_off;

    // LENGTH is a power of two, so IDX_W-bit addition wraps modulo LENGTH.
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_rot
        assign rot_req[gi] = req[IDX_W'(gi) + ptr];
    end

    always_comb begin
        rot_off = '0;
        for (int i = LENGTH - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_off = IDX_W'(i);
            end
        end
    end

    assign any     = |req;
    assign gnt_idx = any ? (rot_off + ptr) : '0;

endmodule

// File: rtl/piso_buffer.sv
// Parallel-input single-output slot buffer: each producer owns one slot, a
// single consumer drains occupied slots in round-robin order.
module piso_buffer
    import reusable_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               d_inp [LENGTH-1:0],
    input  logic [LENGTH-1:0]              ld_ps,
    output logic [LENGTH-1:0]              used_pos,
    output logic [LENGTH-1:0]              ld_rej,
    output logic [WIDTH-1:0]               d_out,
    output logic [clog2_min1(LENGTH)-1:0]  out_idx,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int IDX_W = clog2_min1(LENGTH);

    logic [WIDTH-1:0]  dat_q [LENGTH];
    logic [LENGTH-1:0] used_q, used_d;
    logic [LENGTH-1:0] rej_q, rej_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]  sel;
    logic              any_used;
    logic              pop;
    logic [LENGTH-1:0] pop_slot;
    logic [LENGTH-1:0] load_en;

    rr_select #(.LENGTH(LENGTH)) u_sel (
        .req     (used_q),
        .ptr     (rr_ptr_q),
        .gnt_idx (sel),
        .any     (any_used)
    );

    assign pop = any_used && out_ready;

    // A slot being popped this edge is free again, so its producer may refill it.
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_slot
        assign pop_slot[gi] = pop && (sel == IDX_W'(gi));
        assign load_en[gi]  = ld_ps[gi] && (!used_q[gi] || pop_slot[gi]);
        assign rej_d[gi]    = ld_ps[gi] && used_q[gi] && !pop_slot[gi];
        assign used_d[gi]   = load_en[gi] || (used_q[gi] && !pop_slot[gi]);
    end

    assign rr_ptr_d = pop ? (sel + IDX_W'(1)) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q   <= '0;
            rej_q    <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            used_q   <= used_d;
            rej_q    <= rej_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < LENGTH; i++) begin
                if (load_en[i]) begin
                    dat_q[i] <= d_inp[i];
                end
            end
        end
    end

    assign used_pos  = used_q;
    assign ld_rej    = rej_q;
    assign out_valid = any_used;
    assign out_idx   = any_used ? sel : '0;
    assign d_out     = any_used ? dat_q[sel] : '0;

endmodule

// File: tb/tb_piso_buffer.sv
// Directed bench for piso_buffer: expected pops are queued when slots are
// loaded and compared against the output port at each handshake.
module tb_piso_buffer;

    localparam int WIDTH  = 32;
    localparam int LENGTH = 8;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  d_inp [LENGTH-1:0];
    logic [LENGTH-1:0] ld_ps;
    logic [LENGTH-1:0] used_pos;
    logic [LENGTH-1:0] ld_rej;
    logic [WIDTH-1:0]  d_out;
    logic [2:0]        out_idx;
    logic              out_valid;
    logic              out_ready;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    piso_buffer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_inp     (d_inp),
        .ld_ps     (ld_ps),
        .used_pos  (used_pos),
        .ld_rej    (ld_rej),
        .d_out     (d_out),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input int idx, input logic [31:0] data);
        exp_t e;
        e.idx  = 3'(idx);
        e.data = data;
        sb.push_back(e);
    endtask

    // Compare the currently presented item with the scoreboard head.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_idx"}, 32'(out_idx), 32'(e.idx));
            check({tag, "_data"}, d_out, e.data);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        ld_ps     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < LENGTH; i++) d_inp[i] = '0;

        // Reset state
        do_reset();
        check("rst_used", 32'(used_pos), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_rej", 32'(ld_rej), 32'h0);
        check("rst_idx", 32'(out_idx), 32'h0);
        check("rst_dout", d_out, 32'h0);

        // Single load, visible after one edge
        ld_ps = 8'h08; d_inp[3] = 32'hA5;
        step();
        ld_ps = '0;
        check("t1_used", 32'(used_pos), 32'h08);
        push(3, 32'hA5);
        out_ready = 1'b1;
        sb_check("t1_pop");
        step();
        out_ready = 1'b0;
        check("t1_empty", 32'(used_pos), 32'h0);

        // Three loads drained in order 0,2,5
        do_reset();
        ld_ps = 8'b0010_0101;
        d_inp[0] = 32'h10; d_inp[2] = 32'h20; d_inp[5] = 32'h50;
        step();
        ld_ps = '0;
        push(0, 32'h10); push(2, 32'h20); push(5, 32'h50);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_check("t2_pop");
            step();
        end
        out_ready = 1'b0;
        check("t2_valid", 32'(out_valid), 32'h0);
        check("t2_rrptr", 32'(dut.rr_ptr_q), 32'h6);

        // Fill all slots, rejected load into slot 4
        ld_ps = 8'hFF;
        for (int i = 0; i < LENGTH; i++) d_inp[i] = 32'h100 + 32'(i);
        step();
        check("t3_full", 32'(used_pos), 32'hFF);
        ld_ps = 8'h10; d_inp[4] = 32'hDEAD;
        step();
        ld_ps = '0;
        check("t3_rej", 32'(ld_rej), 32'h10);
        check("t3_used", 32'(used_pos), 32'hFF);
        step();
        check("t3_rej_clr", 32'(ld_rej), 32'h0);
        for (int k = 0; k < LENGTH; k++) push((6 + k) % LENGTH, 32'h100 + 32'((6 + k) % LENGTH));
        out_ready = 1'b1;
        for (int k = 0; k < LENGTH; k++) begin
            sb_check("t3_drain");
            step();
        end
        out_ready = 1'b0;
        check("t3_empty", 32'(used_pos), 32'h0);

        // Pop of slot 7 with simultaneous reload, pointer wraps to 0
        ld_ps = 8'hC0; d_inp[6] = 32'h66; d_inp[7] = 32'h71;
        step();
        ld_ps = '0;
        push(6, 32'h66);
        out_ready = 1'b1;
        sb_check("t4_pop6");
        step();
        check("t4_rr7", 32'(dut.rr_ptr_q), 32'h7);
        push(7, 32'h71);
        ld_ps = 8'h80; d_inp[7] = 32'h77;
        sb_check("t4_pop7");
        step();
        ld_ps = '0;
        out_ready = 1'b0;
        check("t4_used", 32'(used_pos), 32'h80);
        check("t4_rej", 32'(ld_rej), 32'h0);
        check("t4_rr0", 32'(dut.rr_ptr_q), 32'h0);
        push(7, 32'h77);
        out_ready = 1'b1;
        sb_check("t4_reload");
        step();
        out_ready = 1'b0;

        // rr_ptr=2 with slots 1 and 6 pending: slot 6 first
        do_reset();
        ld_ps = 8'h02; d_inp[1] = 32'h11;
        step();
        ld_ps = '0;
        push(1, 32'h11);
        out_ready = 1'b1;
        sb_check("t5_prep");
        step();
        out_ready = 1'b0;
        ld_ps = 8'h42; d_inp[1] = 32'h21; d_inp[6] = 32'h66;
        step();
        ld_ps = '0;
        push(6, 32'h66); push(1, 32'h21);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb_check("t5_pop");
            step();
        end
        out_ready = 1'b0;
        check("t5_valid", 32'(out_valid), 32'h0);

        // Full and popping with all producers loading, then reset mid-flight
        do_reset();
        ld_ps = 8'hFF;
        for (int i = 0; i < LENGTH; i++) d_inp[i] = 32'h200 + 32'(i);
        step();
        check("t6_full", 32'(used_pos), 32'hFF);
        out_ready = 1'b1;
        check("t6_idx0", 32'(out_idx), 32'h0);
        step();
        check("t6_rej_a", 32'(ld_rej), 32'hFE);
        check("t6_used_a", 32'(used_pos), 32'hFF);
        check("t6_rr1", 32'(dut.rr_ptr_q), 32'h1);
        step();
        check("t6_rej_b", 32'(ld_rej), 32'hFD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_ps = '0;
        out_ready = 1'b0;
        check("t6_used", 32'(used_pos), 32'h0);
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_rej", 32'(ld_rej), 32'h0);
        check("t6_rr", 32'(dut.rr_ptr_q), 32'h0);
        check("t6_dout", d_out, 32'h0);
        step();
        check("t6_hold", 32'(used_pos), 32'h0);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
